// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE FSM, DIV-cycle prescaler, 4-digit BCD
// counter with sticky wrap flag and a lap-hold display freeze.
module stopwatch_ctrl #(
  parameter int DIV = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  output logic        tick,
  output logic [15:0] cnt,
  output logic [15:0] disp,
  output logic        running,
  output logic        lap_hold,
  output logic        overflow,
  output logic [1:0]  fsm_state
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] pre;
  logic [15:0]   lap_reg;
  logic [15:0]   cnt_inc;
  logic          carry;

  // clear beats stop beats start; stop is meaningless outside RUN.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (stop)  state_next = PAUSE;
        PAUSE:   if (start) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  assign tick = (state == RUN) && (pre == PRE_LAST) && !clear && !stop;

  // Ripple BCD increment; a digit only moves when all lower digits wrap.
  always_comb begin
    cnt_inc = cnt;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cnt[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pre      <= '0;
      cnt      <= '0;
      lap_reg  <= '0;
      lap_hold <= 1'b0;
      overflow <= 1'b0;
      running  <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
      if (clear) begin
        pre      <= '0;
        cnt      <= '0;
        lap_hold <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (tick) begin
          pre <= '0;
          cnt <= cnt_inc;
          if (cnt == 16'h9999) overflow <= 1'b1;
        end else if (state == RUN && !stop) begin
          pre <= pre + 1'b1;
        end
        // Lap captures the pre-update count, so the frozen value is what was shown.
        if (lap) begin
          if (lap_hold) begin
            lap_hold <= 1'b0;
          end else if (state == RUN) begin
            lap_reg  <= cnt;
            lap_hold <= 1'b1;
          end
        end
      end
    end
  end

  assign disp      = lap_hold ? lap_reg : cnt;
  assign fsm_state = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (DIV=4): directed stimulus, a step-counting model
// compared every cycle, and hand-computed literal expectations.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic        tick;
  logic [15:0] cnt;
  logic [15:0] disp;
  logic        running;
  logic        lap_hold;
  logic        overflow;
  logic [1:0]  fsm_state;

  int checks = 0;
  int failures = 0;

  stopwatch_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .lap(lap), .tick(tick), .cnt(cnt), .disp(disp), .running(running),
    .lap_hold(lap_hold), .overflow(overflow), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Model: count of prescaler-advancing RUN cycles since the last clear.
  int          m_mode;
  int          m_steps;
  bit          m_lap_hold;
  logic [15:0] m_lap_val;

  function automatic logic [15:0] to_bcd(input int n);
    int v;
    logic [15:0] r;
    v = n % 10000;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic logic [15:0] m_cnt();
    return to_bcd(m_steps / DIV);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode     = M_IDLE;
      m_steps    = 0;
      m_lap_hold = 1'b0;
      m_lap_val  = '0;
    end else if (clear) begin
      m_mode     = M_IDLE;
      m_steps    = 0;
      m_lap_hold = 1'b0;
    end else begin
      if (lap) begin
        if (m_lap_hold) m_lap_hold = 1'b0;
        else if (m_mode == M_RUN) begin
          m_lap_val  = m_cnt();
          m_lap_hold = 1'b1;
        end
      end
      if (m_mode == M_RUN && !stop) m_steps++;
      if (m_mode == M_RUN && stop) m_mode = M_PAUSE;
      else if (m_mode != M_RUN && start) m_mode = M_RUN;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic exp_tick;
    exp_tick = !reset && (m_mode == M_RUN) && (m_steps % DIV == DIV - 1) && !clear && !stop;
    check("model_tick", 16'(tick), 16'(exp_tick));
    check("model_cnt", cnt, m_cnt());
    check("model_disp", disp, m_lap_hold ? m_lap_val : m_cnt());
    check("model_running", 16'(running), 16'(m_mode == M_RUN));
    check("model_lap_hold", 16'(lap_hold), 16'(m_lap_hold));
    check("model_overflow", 16'(overflow), 16'(m_steps / DIV >= 10000));
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; step(1); lap = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_cnt", cnt, 16'h0000);
    check("rst_disp", disp, 16'h0000);
    check("rst_running", 16'(running), 16'd0);
    check("rst_tick", 16'(tick), 16'd0);
    check("rst_overflow", 16'(overflow), 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1);

    // First ticks at RUN cycles 4, 8, 12.
    pulse_start();
    check("run_after_start", 16'(running), 16'd1);
    step(3);
    check("first_tick", 16'(tick), 16'd1);
    step(1);
    check("cnt_1", cnt, 16'h0001);
    check("no_tick_after", 16'(tick), 16'd0);
    step(4);
    check("cnt_2", cnt, 16'h0002);
    step(4);
    check("cnt_3", cnt, 16'h0003);
    step(24);
    check("cnt_9", cnt, 16'h0009);
    step(4);
    check("cnt_10", cnt, 16'h0010);

    // Lap freeze and release.
    pulse_clear();
    check("clear_cnt", cnt, 16'h0000);
    check("clear_running", 16'(running), 16'd0);
    pulse_start();
    step(20);
    check("cnt_5", cnt, 16'h0005);
    pulse_lap();
    check("lap_set", 16'(lap_hold), 16'd1);
    check("lap_disp_5", disp, 16'h0005);
    step(11);
    check("lap_cnt_8", cnt, 16'h0008);
    check("lap_disp_still_5", disp, 16'h0005);
    pulse_lap();
    check("lap_released", 16'(lap_hold), 16'd0);
    check("lap_disp_8", disp, 16'h0008);

    // Pause at prescaler phase 2, resume keeps the phase.
    step(1);
    stop = 1'b1; step(1); stop = 1'b0;
    check("paused", 16'(running), 16'd0);
    step(10);
    check("pause_hold_cnt", cnt, 16'h0008);
    pulse_start();
    check("resumed", 16'(running), 16'd1);
    check("resume_no_tick", 16'(tick), 16'd0);
    step(1);
    check("resume_tick", 16'(tick), 16'd1);
    check("resume_cnt_8", cnt, 16'h0008);
    step(1);
    check("resume_cnt_9", cnt, 16'h0009);

    // Long run across digit boundaries and the 9999 wrap.
    pulse_clear();
    pulse_start();
    step(3996);
    check("cnt_0999", cnt, 16'h0999);
    step(4);
    check("cnt_1000", cnt, 16'h1000);
    step(35996);
    check("cnt_9999", cnt, 16'h9999);
    check("no_ovf_yet", 16'(overflow), 16'd0);
    step(4);
    check("wrap_cnt", cnt, 16'h0000);
    check("wrap_ovf", 16'(overflow), 16'd1);
    step(7);
    check("ovf_sticky", 16'(overflow), 16'd1);
    check("count_continues", cnt, 16'h0001);
    pulse_clear();
    check("ovf_cleared", 16'(overflow), 16'd0);

    // All requests at once: clear wins.
    pulse_start();
    step(5);
    start = 1'b1; stop = 1'b1; clear = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
    check("all_req_running", 16'(running), 16'd0);
    check("all_req_cnt", cnt, 16'h0000);

    // lap together with clear: clear wins.
    pulse_start();
    step(6);
    pulse_lap();
    check("lap_before_clear", 16'(lap_hold), 16'd1);
    lap = 1'b1; clear = 1'b1;
    step(1);
    lap = 1'b0; clear = 1'b0;
    check("lap_clear_hold", 16'(lap_hold), 16'd0);

    // Asynchronous reset mid-RUN.
    pulse_start();
    step(6);
    pulse_lap();
    step(3);
    reset = 1'b1;
    #2;
    check("async_cnt", cnt, 16'h0000);
    check("async_disp", disp, 16'h0000);
    check("async_running", 16'(running), 16'd0);
    check("async_tick", 16'(tick), 16'd0);
    check("async_lap_hold", 16'(lap_hold), 16'd0);
    check("async_overflow", 16'(overflow), 16'd0);
    #1;
    reset = 1'b0;
    step(8);
    check("post_reset_cnt", cnt, 16'h0000);
    check("post_reset_running", 16'(running), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
